// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator and its control sequencer.
package cic_pkg;

  // Default filter geometry; the sequencer and the CIC instance must agree.
  localparam int unsigned CIC_N       = 5;
  localparam int unsigned CIC_M       = 2;
  localparam int unsigned CIC_MAXRATE = 64;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } ctrl_state_t;

  // Limit a requested decimation rate to the range the CIC supports.
  function automatic int unsigned clamp_rate(input int unsigned rate,
                                             input int unsigned max_rate);
    if (rate < 32'd2) begin
      return 32'd2;
    end else if (rate > max_rate) begin
      return max_rate;
    end else begin
      return rate;
    end
  endfunction

endpackage

// File: rtl/cic_rate_counter.sv
// Modulo-rate counter: counts enabled events, wraps after rate-1 and flags
// the terminal count combinationally so the caller can act in the same cycle.
module cic_rate_counter #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] rate,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;

  assign tc = (cnt_q == (rate - WIDTH'(1)));

  // Count position within the current decimation period; clear wins over count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: gates input strobes, generates the decimation
// strobe, resets and flushes the CIC after a rate change or sync, and only
// qualifies CIC output samples once the comb history has been flushed.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int unsigned N          = CIC_N,
  parameter int unsigned M          = CIC_M,
  parameter int unsigned MAXRATE    = CIC_MAXRATE,
  parameter int unsigned RATE_WIDTH = 7,
  parameter int unsigned FLUSH_LEN  = N * M + N + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic                  rate_wr_i,
  input  logic                  sync_i,
  output logic                  cic_rst_o,
  output logic                  act_o,
  output logic                  act_out_o,
  output logic                  strobe_o,
  output logic                  settled_o,
  output logic [RATE_WIDTH-1:0] rate_o
);

  localparam int unsigned           FCNT_W    = $clog2(FLUSH_LEN + 1);
  localparam logic [RATE_WIDTH-1:0] RATE_MAX  = RATE_WIDTH'(MAXRATE);
  localparam logic [FCNT_W-1:0]     FCNT_LAST = FCNT_W'(FLUSH_LEN - 1);

  ctrl_state_t           state;
  ctrl_state_t           state_nxt;
  logic [RATE_WIDTH-1:0] rate_pend;
  logic [RATE_WIDTH-1:0] rate_cur;
  logic [FCNT_W-1:0]     fcnt;
  logic                  active;
  logic                  act;
  logic                  act_out;
  logic                  dec_tc;
  logic                  reload;
  logic                  load_go;
  logic                  flush_done;
  logic                  strobe_p1;

  // Samples reach the CIC only while it is out of reset and the block is enabled.
  assign active     = (state == ST_FLUSH) || (state == ST_RUN);
  assign act        = en_i & valid_i & active;
  assign act_out    = act & dec_tc;
  // A rate write or sync re-arms the CIC from any non-idle state.
  assign reload     = en_i & (rate_wr_i | sync_i);
  assign load_go    = en_i & (state == ST_LOAD);
  assign flush_done = act_out & (fcnt == FCNT_LAST);

  // Decimation phase counter; restarted on every LOAD so phase follows sync.
  cic_rate_counter #(
    .WIDTH (RATE_WIDTH)
  ) u_dcnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (act),
    .clr   (load_go),
    .rate  (rate_cur),
    .tc    (dec_tc)
  );

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending rate: clamped on write, independent of enable so it can be set up early.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rate_pend <= RATE_MAX;
    end else if (rate_wr_i) begin
      rate_pend <= RATE_WIDTH'(clamp_rate(32'(rate_i), MAXRATE));
    end
  end

  // Applied rate only changes while the CIC is held in reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rate_cur <= RATE_MAX;
    end else if (load_go) begin
      rate_cur <= rate_pend;
    end
  end

  // Flush counter: decimated outputs discarded since the last CIC reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fcnt <= '0;
    end else if (load_go) begin
      fcnt <= '0;
    end else if ((state == ST_FLUSH) && act_out && (fcnt != FCNT_LAST)) begin
      fcnt <= fcnt + FCNT_W'(1);
    end
  end

  // CIC data_o is valid the cycle after act_out; drop it if RUN is being left.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      strobe_p1 <= 1'b0;
    end else begin
      strobe_p1 <= act_out & (state == ST_RUN) & (state_nxt == ST_RUN);
    end
  end

  // Next-state logic and outputs decoded from the state register.
  always_comb begin
    state_nxt = state;
    cic_rst_o = 1'b0;
    settled_o = 1'b0;
    act_o     = act;
    act_out_o = act_out;
    strobe_o  = 1'b0;
    rate_o    = rate_cur;

    unique case (state)
      ST_IDLE: begin
        cic_rst_o = 1'b1;
        if (en_i) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cic_rst_o = 1'b1;
        if (reload) begin
          state_nxt = ST_LOAD;
        end else if (en_i) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (reload) begin
          state_nxt = ST_LOAD;
        end else if (flush_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        settled_o = 1'b1;
        strobe_o  = strobe_p1 & en_i;
        if (reload) begin
          state_nxt = ST_LOAD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cic_rst_o = 1'b1;
      end
    endcase
  end

endmodule
